// File: rtl/quadrature_generator.sv
// quadrature_generator: memory-mapped A/B quadrature source.
// Emits a commanded number of signed steps at a programmable rate.
// Each step moves the A/B phase one position forward or backward.
// Registers: 0 = steps (signed remaining), 1 = period, 2 = position, 3 = status.
module quadrature_generator #(
    parameter int unsigned           WIDTH          = 16,
    parameter logic [WIDTH-1:0]      DEFAULT_PERIOD = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done
);

    // The state encoding is the {a,b} pair itself, so a/b come straight off flops.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    localparam logic [1:0]       REG_STEPS    = 2'd0;
    localparam logic [1:0]       REG_PERIOD   = 2'd1;
    localparam logic [1:0]       REG_POSITION = 2'd2;
    localparam logic [1:0]       REG_STATUS   = 2'd3;
    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO         = '0;

    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_position;
    logic [WIDTH-1:0] r_timer;
    phase_t           r_phase;
    logic             r_busy;
    logic             r_done;

    logic             w_wr_steps;
    logic             w_wr_period;
    logic             w_wr_position;
    logic             w_active;
    logic             w_forward;
    logic             w_step;
    logic [WIDTH-1:0] w_steps_wdata;
    logic [WIDTH-1:0] w_period_wdata;
    logic [WIDTH-1:0] w_position_wdata;
    logic [WIDTH-1:0] w_steps_next;

    // Merge a write into the current value, one byte lane at a time.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       lanes,
        input logic [WIDTH-1:0] data
    );
        logic [WIDTH-1:0] res;
        res = cur;
        if (lanes[0]) res[7:0]       = data[7:0];
        if (lanes[1]) res[WIDTH-1:8] = data[WIDTH-1:8];
        return res;
    endfunction

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic phase_t phase_fwd(input phase_t cur);
        phase_t nxt;
        nxt = PH_00;
        case (cur)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            PH_01:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    // Reverse order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_t phase_rev(input phase_t cur);
        phase_t nxt;
        nxt = PH_00;
        case (cur)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    assign w_wr_steps    = (addr == REG_STEPS)    && (we != 2'b00);
    assign w_wr_period   = (addr == REG_PERIOD)   && (we != 2'b00);
    assign w_wr_position = (addr == REG_POSITION) && (we != 2'b00);

    assign w_steps_wdata    = byte_merge(r_steps,    we, din);
    assign w_period_wdata   = byte_merge(r_period,   we, din);
    assign w_position_wdata = byte_merge(r_position, we, din);

    assign w_active  = (r_steps != ZERO);
    assign w_forward = ~r_steps[WIDTH-1];

    // A step event is suppressed by any steps or position write on the same cycle.
    // With a position write the whole event is dropped, so the preset value stays
    // consistent with the phase. The timer is still at or above period,
    // so the step is retried on the next cycle.
    assign w_step = w_active && (r_timer >= r_period) && !w_wr_steps && !w_wr_position;

    assign w_steps_next = w_forward ? (r_steps - ONE) : (r_steps + ONE);

    // Register file, rate timer and phase FSM, all updated on one clock.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_steps    <= ZERO;
            r_period   <= DEFAULT_PERIOD;
            r_position <= ZERO;
            r_timer    <= ZERO;
            r_phase    <= PH_00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_wr_period) begin
                r_period <= w_period_wdata;
            end

            if (w_wr_steps) begin
                // A new count replaces the old one; phase and position carry on.
                r_steps <= w_steps_wdata;
                r_busy  <= (w_steps_wdata != ZERO);
                r_timer <= ZERO;
                r_done  <= 1'b0;
            end else if (w_step) begin
                r_steps    <= w_steps_next;
                r_busy     <= (w_steps_next != ZERO);
                r_timer    <= ZERO;
                r_done     <= (w_steps_next == ZERO);
                r_phase    <= w_forward ? phase_fwd(r_phase) : phase_rev(r_phase);
                r_position <= w_forward ? (r_position + ONE) : (r_position - ONE);
            end else begin
                r_timer <= w_active ? (r_timer + ONE) : ZERO;
                r_done  <= 1'b0;
            end

            if (w_wr_position) begin
                r_position <= w_position_wdata;
            end
        end
    end

    // Combinational read mux.
    // NOTE: q gets a default before the case so no path can infer a latch.
    always_comb begin
        q = ZERO;
        case (addr)
            REG_STEPS:    q = r_steps;
            REG_PERIOD:   q = r_period;
            REG_POSITION: q = r_position;
            REG_STATUS:   q = {{(WIDTH-1){1'b0}}, r_busy};
            default:      q = ZERO;
        endcase
    end

    assign a    = r_phase[1];
    assign b    = r_phase[0];
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_quadrature_generator.sv
// Self-checking bench for quadrature_generator.
// The reference model predicts every cycle from the step schedule alone.
// Edge k of a move lands k*(period+1) cycles after the steps write.
// Phase index, position, busy and done all follow from the number of edges so far.
module tb_quadrature_generator;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [1:0]  addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic [15:0] q;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    // Model state: phase index (0:00 1:10 2:11 3:01) and position.
    int          model_idx;
    logic [15:0] model_pos;

    // Loopback encoder: counts quadrature edges seen on a/b.
    logic [1:0] enc_prev;
    int         enc_count;
    int         enc_drops;

    quadrature_generator #(.WIDTH(16), .DEFAULT_PERIOD(16'd2047)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .q    (q),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done)
    );

    // Gated clock so reset can be exercised with no clock running.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Encoder sampling a/b away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            case ({enc_prev, a, b})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: enc_count <= enc_count + 1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                    enc_count <= enc_count - 1;
                    enc_drops <= enc_drops + 1;
                end
                default: ;
            endcase
        end
        enc_prev <= {a, b};
    end

    function automatic logic [1:0] ab_of(input int idx);
        logic [1:0] r;
        case (idx & 3)
            0:       r = 2'b00;
            1:       r = 2'b10;
            2:       r = 2'b11;
            default: r = 2'b01;
        endcase
        return r;
    endfunction

    // Drive one write starting at a negedge; the DUT takes it at the next posedge.
    // Returns at the following negedge, one half-cycle after the write edge.
    task automatic write_reg(input logic [1:0] ad, input logic [1:0] w, input logic [15:0] d);
        addr = ad;
        we   = w;
        din  = d;
        @(negedge clk);
        we   = 2'b00;
        addr = 2'd2;
    endtask

    task automatic read_check(input string tag, input logic [1:0] ad, input logic [15:0] exp);
        addr = ad;
        #1;
        checks++;
        if (q !== exp) begin
            failures++;
            $display("FAIL %s: q=0x%04h expected 0x%04h", tag, q, exp);
        end
    endtask

    // Check the n_cyc cycles after a steps write (count s, period p), then advance the model.
    // Ends just before the posedge n_cyc cycles after the write, so a write issued next
    // lands on that edge.
    task automatic check_span(input string tag, input int s, input int p, input int n_cyc);
        int          mag;
        int          sgn;
        int          e;
        int          idx;
        logic [15:0] exp_pos;
        logic        exp_busy;
        logic        exp_done;
        mag     = (s < 0) ? -s : s;
        sgn     = (s < 0) ? -1 : 1;
        idx     = model_idx;
        exp_pos = model_pos;
        addr    = 2'd2;
        for (int t = 0; t < n_cyc; t++) begin
            #1;
            e = t / (p + 1);
            if (e > mag) e = mag;
            idx      = (model_idx + sgn * e) & 3;
            exp_pos  = model_pos + 16'(sgn * e);
            exp_busy = (e < mag);
            exp_done = (mag != 0) && (t == mag * (p + 1));
            checks++;
            if ({a, b} !== ab_of(idx)) begin
                failures++;
                $display("FAIL %s ab t=%0d: got %b expected %b", tag, t, {a, b}, ab_of(idx));
            end
            checks++;
            if (q !== exp_pos) begin
                failures++;
                $display("FAIL %s position t=%0d: got 0x%04h expected 0x%04h", tag, t, q, exp_pos);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy t=%0d: got %b expected %b", tag, t, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL %s done t=%0d: got %b expected %b", tag, t, done, exp_done);
            end
            if (t < n_cyc - 1) @(negedge clk);
        end
        model_idx = idx;
        model_pos = exp_pos;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        #2;
        checks++;
        if ({a, b} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ab_no_clock: got %b expected 00", {a, b});
        end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        read_check("reset_steps",    2'd0, 16'h0000);
        read_check("reset_period",   2'd1, 16'd2047);
        read_check("reset_position", 2'd2, 16'h0000);
        read_check("reset_status",   2'd3, 16'h0000);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        model_idx = 0;
        model_pos = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_forward();
        write_reg(2'd1, 2'b11, 16'd3);
        write_reg(2'd0, 2'b11, 16'd4);
        check_span("forward", 4, 3, 20);
        read_check("forward_position", 2'd2, 16'h0004);
        @(negedge clk);
    endtask

    task automatic test_reverse();
        write_reg(2'd2, 2'b11, 16'h0000);
        model_pos = 16'h0000;
        write_reg(2'd1, 2'b11, 16'd0);
        write_reg(2'd0, 2'b11, 16'hFFFE);
        check_span("reverse", -2, 0, 6);
        read_check("reverse_position", 2'd2, 16'hFFFE);
        read_check("reverse_steps",    2'd0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic test_stop();
        write_reg(2'd2, 2'b11, 16'h0000);
        model_pos = 16'h0000;
        write_reg(2'd1, 2'b11, 16'd9);
        write_reg(2'd0, 2'b11, 16'd100);
        check_span("stop_run", 100, 9, 33);
        write_reg(2'd0, 2'b11, 16'h0000);
        check_span("stop_idle", 0, 9, 60);
        read_check("stop_position", 2'd2, 16'h0003);
        @(negedge clk);
    endtask

    task automatic test_byte_lanes();
        write_reg(2'd1, 2'b11, 16'd2047);
        write_reg(2'd0, 2'b11, 16'h0000);
        write_reg(2'd0, 2'b01, 16'h1234);
        read_check("bytes_steps_lo", 2'd0, 16'h0034);
        read_check("bytes_status_busy", 2'd3, 16'h0001);
        @(negedge clk);
        write_reg(2'd0, 2'b10, 16'hAB00);
        read_check("bytes_steps_hi", 2'd0, 16'hAB34);
        @(negedge clk);
        write_reg(2'd3, 2'b11, 16'hFFFF);
        read_check("bytes_status_ro", 2'd3, 16'h0001);
        read_check("bytes_period_kept", 2'd1, 16'd2047);
        @(negedge clk);
        write_reg(2'd1, 2'b01, 16'h1234);
        read_check("bytes_period_lo", 2'd1, 16'h0734);
        @(negedge clk);
        write_reg(2'd1, 2'b11, 16'd2047);
        write_reg(2'd0, 2'b11, 16'h0000);
        read_check("bytes_status_idle", 2'd3, 16'h0000);
        checks++;
        if ({a, b} !== ab_of(model_idx)) begin
            failures++;
            $display("FAIL bytes_ab_unchanged: got %b expected %b", {a, b}, ab_of(model_idx));
        end
        @(negedge clk);
    endtask

    task automatic test_collision();
        write_reg(2'd1, 2'b11, 16'd5);
        write_reg(2'd0, 2'b11, 16'd10);
        // Second step event would register on edge 12; the new count lands there.
        check_span("collision_pre", 10, 5, 12);
        write_reg(2'd0, 2'b11, 16'd3);
        check_span("collision_post", 3, 5, 3 * 6 + 4);
        read_check("collision_steps", 2'd0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic test_random();
        int          p;
        int          s;
        logic [15:0] pos;
        for (int i = 0; i < 10; i++) begin
            p   = $urandom_range(0, 6);
            s   = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) s = -s;
            pos = 16'($urandom);
            write_reg(2'd2, 2'b11, pos);
            model_pos = pos;
            write_reg(2'd1, 2'b11, 16'(p));
            write_reg(2'd0, 2'b11, 16'(s));
            check_span("random", s, p, ((s < 0) ? -s : s) * (p + 1) + 3);
            @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        int count0;
        int drops0;
        count0 = enc_count;
        drops0 = enc_drops;
        write_reg(2'd1, 2'b11, 16'd31);
        write_reg(2'd0, 2'b11, 16'd50);
        check_span("loopback", 50, 31, 50 * 32 + 4);
        checks++;
        if (enc_count - count0 !== 50) begin
            failures++;
            $display("FAIL loopback_count: got %0d expected 50", enc_count - count0);
        end
        checks++;
        if (enc_drops - drops0 !== 0) begin
            failures++;
            $display("FAIL loopback_monotonic: reverse edges %0d expected 0", enc_drops - drops0);
        end
        @(negedge clk);
    endtask

    task automatic test_min_steps();
        write_reg(2'd2, 2'b11, 16'h0000);
        model_pos = 16'h0000;
        write_reg(2'd1, 2'b11, 16'd0);
        write_reg(2'd0, 2'b11, 16'h8000);
        check_span("min_steps", -32768, 0, 32768 + 4);
        read_check("min_steps_position", 2'd2, 16'h8000);
        read_check("min_steps_steps",    2'd0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n;
        write_reg(2'd1, 2'b11, 16'd2);
        write_reg(2'd0, 2'b11, 16'd20);
        // Stop on a nonzero phase so the asynchronous clear is visible.
        n = (((model_idx + 1) & 3) != 0) ? 4 : 7;
        check_span("pre_reset", 20, 2, n);
        checks++;
        if ({a, b} === 2'b00) begin
            failures++;
            $display("FAIL pre_reset_phase: got %b expected nonzero", {a, b});
        end
        clk_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({a, b} !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_ab: got %b expected 00", {a, b});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_busy: got %b expected 0", busy);
        end
        #10;
        rst    = 1'b0;
        #3;
        clk_en = 1'b1;
        @(negedge clk);
        model_idx = 0;
        model_pos = 16'h0000;
        check_span("post_reset", 0, 2047, 8);
        read_check("post_reset_period", 2'd1, 16'd2047);
        read_check("post_reset_steps",  2'd0, 16'h0000);
    endtask

    initial begin
        clk       = 1'b0;
        clk_en    = 1'b0;
        rst       = 1'b1;
        addr      = 2'd2;
        we        = 2'b00;
        din       = 16'h0000;
        checks    = 0;
        failures  = 0;
        enc_prev  = 2'b00;
        enc_count = 0;
        enc_drops = 0;
        model_idx = 0;
        model_pos = 16'h0000;

        test_reset();
        test_forward();
        test_reverse();
        test_stop();
        test_byte_lanes();
        test_collision();
        test_random();
        test_loopback();
        test_min_steps();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
